button_conditioner: RTL and testbench

- Front-end stage feeding the stopwatch/timer control logic. It converts raw, bouncing, active-low board pushbuttons into clean signals.
- Per button it provides a synchronised, debounced level, single-cycle press and release strobes, and a long-press strobe followed by auto-repeat strobes.
- Downstream logic consumes these strobes directly in place of its own edge detectors.
- All channels are identical and independent.

---
 rtl/button_conditioner.sv | 180 ++++++++++++++++++
 tb/tb_button_conditioner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Turns raw, bouncing, active-low pushbuttons into clean
//               per-channel signals for the stopwatch/timer control logic.
//               Each channel has a 2-flop synchroniser, a stable-count
//               debouncer, press/release strobes, and a hold tracker that
//               emits one long-press strobe followed by periodic auto-repeat
//               strobes while the button stays down.
// Ports       : clk           - system clock
//               rst           - synchronous active-high reset
//               btn_n         - raw asynchronous buttons, 0 = pushed
//               pressed       - debounced level, 1 = pushed
//               press_pulse   - one-cycle strobe on accepted press
//               release_pulse - one-cycle strobe on accepted release
//               long_pulse    - one-cycle strobe when a press lasts
//                               LONG_CYCLES
//               repeat_pulse  - one-cycle strobe every REPEAT_CYCLES after
//                               long_pulse while still held
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int N_BTN         = 4,
    parameter int DEB_CYCLES    = 500000,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] pressed,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] repeat_pulse
);

    localparam int c_DCNT_W = $clog2(DEB_CYCLES);
    localparam int c_HMAX   = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    // Keep the hold counter at least one bit wide when both periods are 1.
    localparam int c_HCNT_W = (c_HMAX > 1) ? $clog2(c_HMAX) : 1;

    localparam logic [c_DCNT_W-1:0] c_DEB_LAST  = c_DCNT_W'(DEB_CYCLES - 1);
    localparam logic [c_HCNT_W-1:0] c_LONG_LAST = c_HCNT_W'(LONG_CYCLES - 1);
    localparam logic [c_HCNT_W-1:0] c_REP_LAST  = c_HCNT_W'(REPEAT_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HELD   = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    // Synchroniser; resets to the released level so reset never looks like a press.
    logic [N_BTN-1:0] r_s1;
    logic [N_BTN-1:0] r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s1 <= btn_n;
            r_s2 <= r_s1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic                r_stable;
        logic [c_DCNT_W-1:0] r_dcnt;
        logic                w_accept;
        logic                w_press_acc;
        logic                w_rel_acc;

        logic [1:0]          r_state;
        logic [1:0]          w_state_nxt;
        logic [c_HCNT_W-1:0] r_hcnt;
        logic [c_HCNT_W-1:0] w_hcnt_nxt;
        logic                w_long;
        logic                w_repeat;

        logic                r_pressed;
        logic                r_press_pulse;
        logic                r_release_pulse;
        logic                r_long_pulse;
        logic                r_repeat_pulse;

        // A level change is accepted on the edge that sees it for the
        // DEB_CYCLES-th consecutive time.
        assign w_accept    = (r_s2[i] != r_stable) && (r_dcnt == c_DEB_LAST);
        assign w_press_acc = w_accept && !r_s2[i];
        assign w_rel_acc   = w_accept &&  r_s2[i];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_stable <= 1'b1;
                r_dcnt   <= '0;
            end else if (r_s2[i] == r_stable) begin
                r_dcnt   <= '0;
            end else if (w_accept) begin
                r_stable <= r_s2[i];
                r_dcnt   <= '0;
            end else begin
                r_dcnt   <= r_dcnt + 1'b1;
            end
        end

        // Release wins over any expiry on the same edge, so a strobe never
        // appears alongside or after the release.
        always_comb begin
            w_state_nxt = r_state;
            w_hcnt_nxt  = r_hcnt;
            w_long      = 1'b0;
            w_repeat    = 1'b0;
            if (w_rel_acc) begin
                w_state_nxt = S_IDLE;
                w_hcnt_nxt  = '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_press_acc) begin
                            w_state_nxt = S_HELD;
                            w_hcnt_nxt  = '0;
                        end
                    end
                    S_HELD: begin
                        if (r_hcnt == c_LONG_LAST) begin
                            w_long      = 1'b1;
                            w_hcnt_nxt  = '0;
                            w_state_nxt = S_REPEAT;
                        end else begin
                            w_hcnt_nxt  = r_hcnt + 1'b1;
                        end
                    end
                    S_REPEAT: begin
                        if (r_hcnt == c_REP_LAST) begin
                            w_repeat    = 1'b1;
                            w_hcnt_nxt  = '0;
                        end else begin
                            w_hcnt_nxt  = r_hcnt + 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                        w_hcnt_nxt  = '0;
                    end
                endcase
            end
        end

        // pressed is updated on the same edge as the stable level so the
        // strobes line up with the first cycle of the new level.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state         <= S_IDLE;
                r_hcnt          <= '0;
                r_pressed       <= 1'b0;
                r_press_pulse   <= 1'b0;
                r_release_pulse <= 1'b0;
                r_long_pulse    <= 1'b0;
                r_repeat_pulse  <= 1'b0;
            end else begin
                r_state         <= w_state_nxt;
                r_hcnt          <= w_hcnt_nxt;
                if (w_accept) begin
                    r_pressed   <= !r_s2[i];
                end
                r_press_pulse   <= w_press_acc;
                r_release_pulse <= w_rel_acc;
                r_long_pulse    <= w_long;
                r_repeat_pulse  <= w_repeat;
            end
        end

        assign pressed[i]       = r_pressed;
        assign press_pulse[i]   = r_press_pulse;
        assign release_pulse[i] = r_release_pulse;
        assign long_pulse[i]    = r_long_pulse;
        assign repeat_pulse[i]  = r_repeat_pulse;
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner. A behavioural
//               model tracks each channel as a delayed input, a run length of
//               disagreeing samples and the time a press was accepted; hold
//               strobes are derived from elapsed time since that press.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int REP = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_n = '1;
    logic [N-1:0] pressed, press_pulse, release_pulse, long_pulse, repeat_pulse;

    button_conditioner #(
        .N_BTN         (N),
        .DEB_CYCLES    (DEB),
        .LONG_CYCLES   (LNG),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_n         (btn_n),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint       cyc = 0;
    logic [N-1:0] m_d1 = '1, m_d2 = '1;   // input as seen one and two edges ago
    logic [N-1:0] m_level = '1;           // accepted raw level
    int           m_run [N];
    longint       m_t_press [N];
    logic [N-1:0] e_pressed = '0, e_pp = '0, e_rp = '0, e_lp = '0, e_rep = '0;

    // Directed pulse tallies (observed from the DUT)
    int cnt_pp [N];
    int cnt_rp [N];
    int cnt_lp [N];
    int cnt_rep [N];

    task automatic clear_counts();
        for (int c = 0; c < N; c++) begin
            cnt_pp[c] = 0; cnt_rp[c] = 0; cnt_lp[c] = 0; cnt_rep[c] = 0;
        end
    endtask

    task automatic model_edge();
        longint h;
        cyc++;
        e_pp = '0; e_rp = '0; e_lp = '0; e_rep = '0;
        if (rst) begin
            m_d1 = '1; m_d2 = '1; m_level = '1;
            for (int c = 0; c < N; c++) m_run[c] = 0;
        end else begin
            for (int c = 0; c < N; c++) begin
                // A new level must be seen DEB times in a row to be believed.
                if (m_d2[c] != m_level[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DEB) begin
                        m_level[c] = m_d2[c];
                        m_run[c] = 0;
                        if (m_d2[c] == 1'b0) begin
                            e_pp[c] = 1'b1;
                            m_t_press[c] = cyc;
                        end else begin
                            e_rp[c] = 1'b1;
                        end
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (!m_level[c] && !e_pp[c]) begin
                    h = cyc - m_t_press[c];
                    if (h == LNG) e_lp[c] = 1'b1;
                    else if (h > LNG && ((h - LNG) % REP) == 0) e_rep[c] = 1'b1;
                end
            end
            m_d2 = m_d1;
            m_d1 = btn_n;
        end
        e_pressed = ~m_level;
    endtask

    task automatic check_outputs();
        checks++;
        assert (pressed === e_pressed) else begin
            errors++;
            $error("FAIL pressed cyc=%0d observed=%b expected=%b", cyc, pressed, e_pressed);
        end
        checks++;
        assert (press_pulse === e_pp) else begin
            errors++;
            $error("FAIL press_pulse cyc=%0d observed=%b expected=%b", cyc, press_pulse, e_pp);
        end
        checks++;
        assert (release_pulse === e_rp) else begin
            errors++;
            $error("FAIL release_pulse cyc=%0d observed=%b expected=%b", cyc, release_pulse, e_rp);
        end
        checks++;
        assert (long_pulse === e_lp) else begin
            errors++;
            $error("FAIL long_pulse cyc=%0d observed=%b expected=%b", cyc, long_pulse, e_lp);
        end
        checks++;
        assert (repeat_pulse === e_rep) else begin
            errors++;
            $error("FAIL repeat_pulse cyc=%0d observed=%b expected=%b", cyc, repeat_pulse, e_rep);
        end
    endtask

    // One clock: model and DUT see the same inputs, outputs checked 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        for (int c = 0; c < N; c++) begin
            cnt_pp[c]  += int'(press_pulse[c]);
            cnt_rp[c]  += int'(release_pulse[c]);
            cnt_lp[c]  += int'(long_pulse[c]);
            cnt_rep[c] += int'(repeat_pulse[c]);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Step until pressed[ch] is seen, bounded.
    task automatic wait_pressed(input int ch, input string tag);
        for (int i = 0; i < 20 && !pressed[ch]; i++) step();
        check_int(tag, int'(pressed[ch]), 1);
    endtask

    int hold [N];

    initial begin
        for (int c = 0; c < N; c++) begin
            m_run[c] = 0; m_t_press[c] = 0;
        end
        clear_counts();

        // Reset with all buttons held
        rst = 1'b1; btn_n = 4'b0000;
        repeat (3) step();
        check_vec("reset_outputs", pressed | press_pulse | release_pulse | long_pulse | repeat_pulse, 4'b0000);
        rst = 1'b0;
        repeat (5) step();
        check_vec("post_reset_early", press_pulse, 4'b0000);
        step();
        check_vec("post_reset_pressed", pressed, 4'b1111);
        check_vec("post_reset_press_pulse", press_pulse, 4'b1111);
        btn_n = 4'b1111;
        repeat (12) step();
        clear_counts();

        // Clean press and release on channel 0
        btn_n[0] = 1'b0;
        repeat (12) step();
        check_int("clean_pressed0", int'(pressed[0]), 1);
        btn_n[0] = 1'b1;
        repeat (12) step();
        check_int("clean_press_cnt", cnt_pp[0], 1);
        check_int("clean_release_cnt", cnt_rp[0], 1);
        clear_counts();

        // Bounce rejection on channel 1, then a just-long-enough pulse
        repeat (10) begin
            btn_n[1] = 1'b0; repeat (3) step();
            btn_n[1] = 1'b1; step();
        end
        repeat (10) step();
        check_int("bounce_press_cnt", cnt_pp[1], 0);
        btn_n[1] = 1'b0; repeat (DEB) step();
        btn_n[1] = 1'b1; repeat (14) step();
        check_int("min_pulse_press_cnt", cnt_pp[1], 1);
        check_int("min_pulse_release_cnt", cnt_rp[1], 1);
        clear_counts();

        // Long press with repeats on channel 2; release accepted at index 56
        btn_n[2] = 1'b0;
        wait_pressed(2, "long_wait_pressed");
        repeat (50) step();
        btn_n[2] = 1'b1;
        repeat (25) step();
        check_int("long_cnt", cnt_lp[2], 1);
        check_int("repeat_cnt", cnt_rep[2], 4);
        check_int("long_release_cnt", cnt_rp[2], 1);
        clear_counts();

        // Release accepted on the same edge the long count expires
        btn_n[0] = 1'b0;
        repeat (LNG) step();
        btn_n[0] = 1'b1;
        repeat (30) step();
        check_int("collide_long_cnt", cnt_lp[0], 0);
        check_int("collide_release_cnt", cnt_rp[0], 1);
        clear_counts();

        // Reset during REPEAT on channel 3 while still held
        btn_n[3] = 1'b0;
        wait_pressed(3, "rst_hold_wait_pressed");
        repeat (LNG + 10) step();
        rst = 1'b1;
        step();
        check_vec("mid_reset_outputs", pressed | press_pulse | release_pulse | long_pulse | repeat_pulse, 4'b0000);
        rst = 1'b0;
        repeat (5) step();
        check_int("mid_reset_no_release", cnt_rp[3], 0);
        step();
        check_vec("mid_reset_repress", press_pulse, 4'b1000);
        btn_n[3] = 1'b1;
        repeat (12) step();

        // Randomised traffic with independent per-channel hold times
        for (int c = 0; c < N; c++) hold[c] = 1;
        for (int t = 0; t < 1500; t++) begin
            for (int c = 0; c < N; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    btn_n[c] = ~btn_n[c];
                    hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                           : int'($urandom_range(1, 7));
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        btn_n = '1;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
